// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiplier/divider.
package multdiv_pkg;

  localparam int WIDTH       = 32;
  localparam int ITERS_R2    = 32;
  localparam int ITERS_BOOTH = 16;
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  // Unsigned magnitude of a signed operand; INT_MIN maps to 2^31 as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c[0] = cin;
    for (int grp = 0; grp < 8; grp++) begin
      c[grp*4+1] = g[grp*4] | (p[grp*4] & c[grp*4]);
      c[grp*4+2] = g[grp*4+1] | (p[grp*4+1] & g[grp*4])
                 | (p[grp*4+1] & p[grp*4] & c[grp*4]);
      c[grp*4+3] = g[grp*4+2] | (p[grp*4+2] & g[grp*4+1])
                 | (p[grp*4+2] & p[grp*4+1] & g[grp*4])
                 | (p[grp*4+2] & p[grp*4+1] & p[grp*4] & c[grp*4]);
      c[grp*4+4] = g[grp*4+3] | (p[grp*4+3] & g[grp*4+2])
                 | (p[grp*4+3] & p[grp*4+2] & g[grp*4+1])
                 | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & g[grp*4])
                 | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & p[grp*4] & c[grp*4]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply/divide with start/ready handshake.
// Define MULTDIV_BOOTH4_EN for a radix-4 Booth multiply (16 iterations).
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = multdiv_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

`ifdef MULTDIV_BOOTH4_EN
  localparam int HI_W = WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_MUL = CNT_W'(ITERS_BOOTH - 1);
`else
  localparam int HI_W = WIDTH;
  localparam logic [CNT_W-1:0] LAST_MUL = CNT_W'(ITERS_R2 - 1);
`endif
  localparam logic [CNT_W-1:0] LAST_DIV = CNT_W'(ITERS_R2 - 1);

  state_t state, state_n;
  logic [CNT_W-1:0] count;
  logic [HI_W-1:0]  hi, hi_n;
  logic [WIDTH-1:0] lo, lo_n, mcand;
  logic             neg, div_zero;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             start, last;

  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  logic               add_cin, add_cout;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quot_s, res_n;
  logic               exc_n;
`ifdef MULTDIV_BOOTH4_EN
  logic               qm1, qm1_n;
  logic [WIDTH+1:0]   bmult, bsum;
  logic [1:0]         top2;
`endif

  assign start = ctrl_MULT | ctrl_DIV;
  assign last  = ((state == MUL) && (count == LAST_MUL))
              || ((state == DIV) && (count == LAST_DIV));

  // One adder serves both the accumulate (MUL) and trial-subtract (DIV) steps.
  cla32 u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clock) begin
    // NOTE: state is written with <= so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = ctrl_MULT ? MUL : DIV;
    end else begin
      case (state)
        MUL, DIV: if (last) state_n = DONE;
        DONE:     state_n = IDLE;
        default:  state_n = state;
      endcase
    end
  end

  // A start in the DONE cycle aborts the finishing op, so its pulse is dropped.
  always_comb begin
    data_resultRDY = (state == DONE) && !start;
    data_exception = data_resultRDY && exc_q;
  end

  assign data_result = result_q;

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    hi_n    = hi;
    lo_n    = lo;
`ifdef MULTDIV_BOOTH4_EN
    qm1_n = qm1;
    bmult = '0;
    bsum  = '0;
    top2  = '0;
`endif
    case (state)
      MUL: begin
`ifdef MULTDIV_BOOTH4_EN
        // Booth digit in {-2,-1,0,+1,+2}; negatives add the inverse with carry-in.
        case ({lo[1:0], qm1})
          3'b001, 3'b010: bmult = {{2{mcand[WIDTH-1]}}, mcand};
          3'b011:         bmult = {mcand[WIDTH-1], mcand, 1'b0};
          3'b100: begin
            bmult   = ~{mcand[WIDTH-1], mcand, 1'b0};
            add_cin = 1'b1;
          end
          3'b101, 3'b110: begin
            bmult   = ~{{2{mcand[WIDTH-1]}}, mcand};
            add_cin = 1'b1;
          end
          default: bmult = '0;
        endcase
        add_a = hi[WIDTH-1:0];
        add_b = bmult[WIDTH-1:0];
        top2  = hi[WIDTH+1:WIDTH] + bmult[WIDTH+1:WIDTH] + {1'b0, add_cout};
        bsum  = {top2, add_sum};
        hi_n  = {{2{bsum[WIDTH+1]}}, bsum[WIDTH+1:2]};
        lo_n  = {bsum[1:0], lo[WIDTH-1:2]};
        qm1_n = lo[1];
`else
        add_a = hi;
        add_b = lo[0] ? mcand : '0;
        hi_n  = {add_cout, add_sum[WIDTH-1:1]};
        lo_n  = {add_sum[0], lo[WIDTH-1:1]};
`endif
      end
      DIV: begin
        // Shifted remainder is below 2*divisor <= 2^32, so 32 bits hold it.
        add_a   = {hi[WIDTH-2:0], lo[WIDTH-1]};
        add_b   = ~mcand;
        add_cin = 1'b1;
        hi_n    = HI_W'(add_cout ? add_sum : add_a);
        lo_n    = {lo[WIDTH-2:0], add_cout};
      end
      default: ;
    endcase
  end

  always_comb begin
    prod_mag = {hi_n[WIDTH-1:0], lo_n};
`ifdef MULTDIV_BOOTH4_EN
    prod = prod_mag;
`else
    prod = neg ? -prod_mag : prod_mag;
`endif
    quot_s = neg ? -lo_n : lo_n;
    if (state == DIV) begin
      res_n = div_zero ? '0 : quot_s;
      exc_n = div_zero || (!neg && lo_n[WIDTH-1]);
    end else begin
      res_n = prod[WIDTH-1:0];
      exc_n = (prod[2*WIDTH-1:WIDTH-1] != '0) && (prod[2*WIDTH-1:WIDTH-1] != '1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      neg      <= 1'b0;
      div_zero <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
      qm1      <= 1'b0;
`endif
    end else if (start) begin
      count    <= '0;
      hi       <= '0;
      neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= (data_operandB == '0);
`ifdef MULTDIV_BOOTH4_EN
      qm1      <= 1'b0;
`endif
      if (ctrl_MULT) begin
`ifdef MULTDIV_BOOTH4_EN
        mcand <= data_operandA;
        lo    <= data_operandB;
`else
        mcand <= magnitude(data_operandA);
        lo    <= magnitude(data_operandB);
`endif
      end else begin
        mcand <= magnitude(data_operandB);
        lo    <= magnitude(data_operandA);
      end
    end else if ((state == MUL) || (state == DIV)) begin
      count <= count + CNT_W'(1);
      hi    <= hi_n;
      lo    <= lo_n;
`ifdef MULTDIV_BOOTH4_EN
      qm1   <= qm1_n;
`endif
      if (last) begin
        result_q <= res_n;
        exc_q    <= exc_n;
      end
    end
  end

endmodule
